// File: rtl/div_issue_ctrl.sv
// Issue sequencer for the iterative 32-bit divider: launches DIV/DIVU, stalls EX
// while the divide runs, captures {rem,quo} into HI/LO and drains after completion or flush.
module div_issue_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_op_i,
    input  logic        div_signed_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic          start_q, start_d;
    logic          signed_q, signed_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic          annul_q, annul_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          whilo_q, whilo_d;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        start_d     = start_q;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        annul_d     = annul_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        whilo_d     = 1'b0;
        stallreq_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_op_i && !flush_i) begin
                    op1_d      = reg1_i;
                    op2_d      = reg2_i;
                    signed_d   = div_signed_i;
                    start_d    = 1'b1;
                    state_d    = BUSY;
                    stallreq_o = 1'b1;
                end
            end
            BUSY: begin
                stallreq_o = ~div_ready_i & ~flush_i;
                // A flush wins over a coinciding result: the instruction is dead.
                if (flush_i) begin
                    start_d     = 1'b0;
                    annul_d     = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = CW'(DRAIN_CYCLES - 1);
                end else if (div_ready_i) begin
                    hi_d        = div_result_i[63:32];
                    lo_d        = div_result_i[31:0];
                    whilo_d     = 1'b1;
                    start_d     = 1'b0;
                    state_d     = DRAIN;
                    drain_cnt_d = CW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                start_d    = 1'b0;
                stallreq_o = div_op_i;
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                    annul_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            start_q     <= 1'b0;
            signed_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            annul_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            whilo_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            start_q     <= start_d;
            signed_q    <= signed_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            annul_q     <= annul_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            whilo_q     <= whilo_d;
        end
    end

    assign div_start_o  = start_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign div_annul_o  = annul_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign whilo_o      = whilo_q;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage sequencer placed directly upstream of the iterative 32-bit divider.
- Accepts DIV/DIVU from the EX stage and latches the operands. Drives the divider's start/signed/operand/annul inputs and stalls the pipeline while the divide is in flight.
- Captures the divider's 64-bit result into a dedicated HI/LO write port: HI = remainder, LO = quotient.
- Also handles pipeline flush (annul) and drains the divider back to its free state before the next issue.

Parameters:
- DRAIN_CYCLES, 2, cycles spent in DRAIN after completion or annul. Must be >= 2 so the divider reaches its free state from any state.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_op_i  in  1  EX holds a DIV or DIVU this cycle.
- div_signed_i  in  1  1 = DIV, 0 = DIVU.
- reg1_i  in  32  dividend (rs).
- reg2_i  in  32  divisor (rt).
- flush_i  in  1  pipeline flush; kills any divide in flight.
- div_result_i  in  64  from divider: {remainder[63:32], quotient[31:0]}.
- div_ready_i  in  1  from divider: result valid.
- div_start_o  out  1  to divider start_i.
- div_signed_o  out  1  to divider signed_div_i.
- div_op1_o  out  32  to divider opdata1_i.
- div_op2_o  out  32  to divider opdata2_i.
- div_annul_o  out  1  to divider annul_i.
- stallreq_o  out  1  stall request to pipeline control (combinational).
- hi_o  out  32  remainder to HI.
- lo_o  out  32  quotient to LO.
- whilo_o  out  1  HI/LO write enable, one-cycle pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; drain counter=0.
  - All registered outputs 0: div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o, hi_o, lo_o, whilo_o.
  - Reset mid-divide abandons the operation; no HI/LO write.
- Registered outputs: everything except stallreq_o.
- whilo_o defaults to 0 every cycle unless set as below.
- IDLE:
  - If div_op_i=1 and flush_i=0:
    - Latch reg1_i, reg2_i and div_signed_i into div_op1_o, div_op2_o and div_signed_o.
    - Set div_start_o=1 and go to BUSY.
    - stallreq_o=1 this cycle.
  - Otherwise stallreq_o=0.
- BUSY:
  - div_start_o stays 1; operands and signed flag stay frozen. The divider re-samples them at completion.
  - stallreq_o = ~div_ready_i & ~flush_i.
  - flush_i=1 (has priority over a simultaneous div_ready_i):
    - div_start_o=0, div_annul_o=1.
    - No whilo_o pulse.
    - Go to DRAIN.
  - Else if div_ready_i=1:
    - hi_o <= div_result_i[63:32]; lo_o <= div_result_i[31:0]; whilo_o <= 1 for one cycle.
    - div_start_o=0.
    - Go to DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles, then go to IDLE.
  - div_start_o=0.
  - div_annul_o holds its entry value, then clears on exit.
  - stallreq_o = div_op_i, so a back-to-back DIV waits in EX.
  - Issue requests are ignored in this state.
  - flush_i in DRAIN has no extra effect.
- Latency with the team's divider, issue in cycle 0:
  - Normal divide: div_ready_i seen in cycle 36; stallreq_o high in cycles 0-35; whilo_o high in cycle 37.
  - Divisor 0: div_ready_i seen in cycle 4; stall in cycles 0-3; whilo_o high in cycle 5; HI=LO=0.
- Signed results come from the divider unmodified:
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of the dividend.

Test Plan:
- DIVU 100/7 issued cycle 0 -> stallreq_o high cycles 0-35; whilo_o pulse cycle 37 with hi_o=2, lo_o=14; back to IDLE by cycle 39.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU on the same operands -> lo_o=0x7FFFFFFC, hi_o=1.
- DIV 5/0 -> stallreq_o high cycles 0-3; whilo_o cycle 5 with hi_o=lo_o=0.
- flush_i in cycle 10 of a divide -> stallreq_o low in cycle 10; div_annul_o=1 and div_start_o=0 in cycles 11-12; no whilo_o. A new DIVU 9/3 presented from cycle 11 issues in cycle 13 and yields lo_o=3, hi_o=0.
- Back-to-back DIVU 10/3 then 20/6, second in EX from cycle 37 -> stallreq_o high throughout DRAIN; both whilo_o pulses present with (hi,lo)=(1,3) then (2,3).
- rst pulsed in cycle 20 of a divide -> all outputs 0 immediately, state IDLE, no whilo_o. A subsequent DIVU 8/2 completes normally: lo_o=4, hi_o=0.
